// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - command, ALU and result signal bundle for alu_issue_ctrl
// The slave modport is the controller side; the master modport is the command source, ALU and result consumer.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [WIDTH-1:0]     cmd_x;
  logic [WIDTH-1:0]     cmd_z;
  logic [1:0]           alu_control;
  logic [WIDTH-1:0]     alu_x;
  logic [WIDTH-1:0]     alu_z;
  logic [2*WIDTH-1:0]   alu_y;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_data;
  logic                 res_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_z, alu_y, res_ready,
    output cmd_ready, alu_control, alu_x, alu_z, res_valid, res_data, res_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_z, alu_y, res_ready,
    input  cmd_ready, alu_control, alu_x, alu_z, res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - sequential issue/capture front end for a combinational add/sub/mul ALU
// Optional result counters are enabled by defining ALU_ISSUE_COUNT_EN.
module alu_issue_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  alu_issue_ctrl_if.slave bus
`ifdef ALU_ISSUE_COUNT_EN
  ,
  output logic [15:0]     op_count,
  output logic [7:0]      err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic                 inv_q, inv_d;
  logic [2*WIDTH-1:0]   data_q, data_d;
  logic                 err_q, err_d;
  logic                 valid_q, valid_d;
  logic                 cmd_ready;
  logic                 accept;

  // Gated by reset_n so every output reads 0 while reset is held.
  assign cmd_ready = reset_n & ((state_q == IDLE) | ((state_q == DONE) & bus.res_ready));
  assign accept    = bus.cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    z_d     = z_q;
    inv_d   = inv_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        data_d  = inv_q ? '0 : bus.alu_y;
        err_d   = inv_q;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          state_d = accept ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Op 3 never reaches the ALU: alu_control keeps its last legal code.
    if (accept) begin
      x_d   = bus.cmd_x;
      z_d   = bus.cmd_z;
      inv_d = (bus.cmd_op == 2'd3);
      if (bus.cmd_op != 2'd3) ctrl_d = bus.cmd_op;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      x_q     <= '0;
      z_q     <= '0;
      inv_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      z_q     <= z_d;
      inv_q   <= inv_d;
      data_q  <= data_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.alu_control = ctrl_q;
  assign bus.alu_x       = x_q;
  assign bus.alu_z       = z_q;
  assign bus.res_valid   = valid_q;
  assign bus.res_data    = data_q;
  assign bus.res_err     = err_q;

`ifdef ALU_ISSUE_COUNT_EN
  logic [15:0] op_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        res_hs;

  assign res_hs = valid_q & bus.res_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (res_hs) begin
      if (!err_q && op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign op_count  = op_cnt_q;
  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed and randomized self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  logic clock;
  logic reset_n;
  int   checks;
  int   failures;
  int   model_ops;
  int   model_errs;
  logic [1:0] last_ctrl;
  logic saw_op3;

  alu_issue_ctrl_if #(.WIDTH(8)) bus ();

`ifdef ALU_ISSUE_COUNT_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  alu_issue_ctrl #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef ALU_ISSUE_COUNT_EN
    ,
    .op_count  (op_count),
    .err_count (err_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational ALU that the controller drives.
  always_comb begin
    bus.alu_y = 16'h0000;
    case (bus.alu_control)
      2'd0: bus.alu_y = {8'h00, bus.alu_x} + {8'h00, bus.alu_z};
      2'd1: bus.alu_y = {8'h00, bus.alu_x} - {8'h00, bus.alu_z};
      2'd2: bus.alu_y = {8'h00, bus.alu_x} * {8'h00, bus.alu_z};
      default: bus.alu_y = 16'hDEAD;
    endcase
  end

  initial saw_op3 = 1'b0;
  always @(negedge clock) if (bus.alu_control === 2'd3) saw_op3 = 1'b1;

  function automatic logic [15:0] exp_res(input int op, input int x, input int z);
    int r;
    case (op)
      0: r = x + z;
      1: r = x - z + 65536;
      2: r = x * z;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_to_done(input logic [1:0] op, input logic [7:0] x, input logic [7:0] z);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_x     = x;
    bus.cmd_z     = z;
    #1;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    if (op != 2'd3) last_ctrl = op;
    chk("exec_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("exec_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("alu_control", {30'd0, bus.alu_control}, {30'd0, last_ctrl});
    chk("alu_x", {24'd0, bus.alu_x}, {24'd0, x});
    chk("alu_z", {24'd0, bus.alu_z}, {24'd0, z});
    step();
    chk("done_res_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("res_data", {16'd0, bus.res_data}, {16'd0, exp_res(int'(op), int'(x), int'(z))});
    chk("res_err", {31'd0, bus.res_err}, {31'd0, op == 2'd3});
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] x, input logic [7:0] z, input int stall);
    logic [15:0] e;
    e = exp_res(int'(op), int'(x), int'(z));
    issue_to_done(op, x, z);
    for (int i = 0; i < stall; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'($urandom_range(0, 3));
      bus.cmd_x     = 8'($urandom);
      bus.cmd_z     = 8'($urandom);
      step();
      chk("stall_res_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("stall_res_data", {16'd0, bus.res_data}, {16'd0, e});
      chk("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    chk("done_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    if (op == 2'd3) model_errs++; else model_ops++;
    bus.res_ready = 1'b0;
    #1;
    chk("idle_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    model_ops  = 0;
    model_errs = 0;
    last_ctrl  = 2'd0;
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_x     = 8'd0;
    bus.cmd_z     = 8'd0;
    bus.res_ready = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("post_rst_res_data", {16'd0, bus.res_data}, 32'd0);

    // Basic ops, sub wrap, full mul product, invalid op
    run_op(2'd0, 8'd200, 8'd100, 0);
    chk("add_value", {16'd0, bus.res_data}, 32'h012C);
    run_op(2'd1, 8'd3, 8'd5, 0);
    chk("sub_wrap", {16'd0, bus.res_data}, 32'hFFFE);
    run_op(2'd2, 8'd255, 8'd255, 0);
    chk("mul_max", {16'd0, bus.res_data}, 32'hFE01);
    run_op(2'd3, 8'd7, 8'd9, 0);
    chk("inv_ctrl_kept", {30'd0, bus.alu_control}, 32'd2);

    // Backpressure with competing commands
    run_op(2'd0, 8'd1, 8'd2, 5);

    // Back-to-back accept from DONE
    issue_to_done(2'd0, 8'd10, 8'd20);
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_x     = 8'd16;
    bus.cmd_z     = 8'd16;
    #1;
    chk("b2b_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    step();
    model_ops++;
    last_ctrl     = 2'd2;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    chk("b2b_exec_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("b2b_alu_control", {30'd0, bus.alu_control}, 32'd2);
    step();
    chk("b2b_res_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("b2b_res_data", {16'd0, bus.res_data}, 32'h0100);
    bus.res_ready = 1'b1;
    step();
    model_ops++;
    bus.res_ready = 1'b0;
    #1;
    chk("b2b_idle_valid", {31'd0, bus.res_valid}, 32'd0);
`ifdef ALU_ISSUE_COUNT_EN
    chk("op_count", {16'd0, op_count}, model_ops);
    chk("err_count", {24'd0, err_count}, model_errs);
`endif

    // Randomized operations with random backpressure
    for (int n = 0; n < 24; n++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end
`ifdef ALU_ISSUE_COUNT_EN
    chk("op_count_rand", {16'd0, op_count}, model_ops);
    chk("err_count_rand", {24'd0, err_count}, model_errs);
`endif

    // Reset in the middle of EXEC
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd2;
    bus.cmd_x     = 8'd9;
    bus.cmd_z     = 8'd9;
    step();
    bus.cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("mid_rst_res_data", {16'd0, bus.res_data}, 32'd0);
    chk("mid_rst_res_err", {31'd0, bus.res_err}, 32'd0);
    chk("mid_rst_alu_control", {30'd0, bus.alu_control}, 32'd0);
    chk("mid_rst_alu_x", {24'd0, bus.alu_x}, 32'd0);
    chk("mid_rst_alu_z", {24'd0, bus.alu_z}, 32'd0);
    last_ctrl  = 2'd0;
    model_ops  = 0;
    model_errs = 0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rel_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      chk("rel_res_valid", {31'd0, bus.res_valid}, 32'd0);
    end
`ifdef ALU_ISSUE_COUNT_EN
    chk("op_count_rst", {16'd0, op_count}, 32'd0);
`endif
    run_op(2'd1, 8'd50, 8'd8, 1);
    chk("alu_control_never_3", {31'd0, saw_op3}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
